// File: rtl/gol_pkg.sv
// Shared types and constants for the Life-like cellular automaton engine.
// Cell packing: bit x*HEIGHT+y holds cell (x,y).
package gol_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [8:0] LIFE_BIRTH   = 9'h008;
  localparam logic [8:0] LIFE_SURVIVE = 9'h00C;

  function automatic int cell_index(
    input int x,
    input int y,
    input int h
  );
    return x * h + y;
  endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Per-cell next-state: count live neighbours, then look up
// the birth or survive mask depending on the current state.
module gol_cell_rule (
  input  logic [7:0] i_nbr,
  input  logic       i_self,
  input  logic [8:0] i_birth,
  input  logic [8:0] i_survive,
  output logic       o_next
);

  logic [3:0] w_cnt;

  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_cnt = w_cnt + {3'd0, i_nbr[i]};
    end
  end

  assign o_next = i_self ? i_survive[w_cnt]
                         : i_birth[w_cnt];

endmodule

// File: rtl/gol_engine.sv
// Life-like grid engine: programmable B/S rules, wrap or dead edges,
// load handshake, run/step/halt control and still/period-2 detection.
module gol_engine
  import gol_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int WRAP   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [WIDTH*HEIGHT-1:0] load_data,
  input  logic [8:0]              rule_birth,
  input  logic [8:0]              rule_survive,
  input  logic                    run,
  input  logic                    step,
  input  logic                    stop_on_still,
  input  logic [CNT_W-1:0]        gen_limit,
  output logic [WIDTH*HEIGHT-1:0] out,
  output logic [CNT_W-1:0]        gen_count,
  output logic                    gen_valid,
  output logic                    still,
  output logic                    osc2,
  output logic                    empty,
  output logic                    busy
);

  localparam int N = WIDTH * HEIGHT;

  logic [N-1:0]     r_grid;
  logic [N-1:0]     r_prev;
  logic [N-1:0]     w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_still;
  logic             r_osc2;
  logic             r_gv;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_evolve;
  logic             w_same;
  logic             w_limit;

  for (genvar gx = 0; gx < WIDTH; gx++) begin : g_x
    for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_y
      localparam int IDX = cell_index(gx, gy, HEIGHT);
      logic [7:0] w_nbr;

      // k walks the 3x3 window, skipping the centre cell.
      for (genvar k = 0; k < 8; k++) begin : g_n
        localparam int K9 = (k < 4) ? k : k + 1;
        localparam int NX = gx + K9 / 3 - 1;
        localparam int NY = gy + K9 % 3 - 1;
        localparam int WX = (NX + WIDTH) % WIDTH;
        localparam int WY = (NY + HEIGHT) % HEIGHT;
        localparam bit INSIDE = (NX >= 0) && (NX < WIDTH) &&
                                (NY >= 0) && (NY < HEIGHT);
        if (WRAP != 0) begin : g_wrap
          localparam int SRC = cell_index(WX, WY, HEIGHT);
          assign w_nbr[k] = r_grid[SRC];
        end else if (INSIDE) begin : g_in
          localparam int SRC = cell_index(NX, NY, HEIGHT);
          assign w_nbr[k] = r_grid[SRC];
        end else begin : g_out
          assign w_nbr[k] = 1'b0;
        end
      end

      gol_cell_rule u_rule (
        .i_nbr     (w_nbr),
        .i_self    (r_grid[IDX]),
        .i_birth   (rule_birth),
        .i_survive (rule_survive),
        .o_next    (w_next[IDX])
      );
    end
  end

  assign load_ready = (r_state != RUN);
  assign w_load     = load_valid & load_ready;
  assign w_evolve   = ~w_load &
                      (((r_state == RUN) & run) |
                       ((r_state == HALT) & step));

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_same    = (w_next == r_grid);
  assign w_limit   = (gen_limit != '0) &&
                     (r_cnt + CNT_W'(1) == gen_limit);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HALT: begin
        if (run) w_state_nxt = RUN;
      end
      RUN: begin
        if (!run) begin
          w_state_nxt = HALT;
        end else if ((stop_on_still && w_same) || w_limit) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!run) w_state_nxt = HALT;
      end
      default: w_state_nxt = HALT;
    endcase
    if (w_load) w_state_nxt = HALT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HALT;
      r_grid  <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_still <= 1'b0;
      r_osc2  <= 1'b0;
      r_gv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gv    <= w_evolve;
      if (w_load) begin
        r_grid  <= load_data;
        r_prev  <= '0;
        r_cnt   <= '0;
        r_still <= 1'b0;
        r_osc2  <= 1'b0;
      end else if (w_evolve) begin
        r_grid  <= w_next;
        r_prev  <= r_grid;
        r_cnt   <= w_cnt_inc;
        r_still <= w_same;
        r_osc2  <= (w_next == r_prev);
      end
    end
  end

  assign out       = r_grid;
  assign gen_count = r_cnt;
  assign gen_valid = r_gv;
  assign still     = r_still;
  assign osc2      = r_osc2;
  assign empty     = (r_grid == '0);
  assign busy      = (r_state == RUN);

endmodule
